// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the DMA controller state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [2:0] {
    DMA_IDLE = 3'd0,
    DMA_REQ  = 3'd1,
    DMA_RD_A = 3'd2,
    DMA_RD_D = 3'd3,
    DMA_WR_A = 3'd4,
    DMA_WR_D = 3'd5,
    DMA_DONE = 3'd6
  } dma_state_t;

endpackage

// File: rtl/ahb_dma_master_if.sv
// AHB-lite master port of the DMA engine, with arbiter request/grant.
interface ahb_dma_master_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  // Handshake: a phase completes on a rising edge where HREADY=1; while
  // HREADY=0 the master holds HADDR/HTRANS/HWRITE/HWDATA unchanged.
  // HBUSREQ stays high until the arbiter answers with HGRANT.
  logic          HBUSREQ;
  logic          HGRANT;
  logic          HREADY;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic          HMASTLOCK;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;

  modport master (
    output HBUSREQ, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HGRANT, HREADY, HRDATA
  );

  modport slave (
    input  HBUSREQ, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HGRANT, HREADY, HRDATA
  );
endinterface

// File: rtl/ahb_dma_master_xfer_ctr.sv
// Source/destination address registers and remaining-word counter of the DMA.
module dma_xfer_ctr #(
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [AW-1:0] i_src,
  input  logic [AW-1:0] i_dst,
  input  logic [CW-1:0] i_cnt,
  output logic [AW-1:0] o_src,
  output logic [AW-1:0] o_dst,
  output logic [CW-1:0] o_remaining,
  output logic          o_last
);

  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [CW-1:0] r_rem;

  // Addresses are doubleword aligned; the +8 step wraps modulo 2^AW.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_src <= i_src & ~AW'(7);
      r_dst <= i_dst & ~AW'(7);
      r_rem <= i_cnt;
    end else if (i_step) begin
      r_src <= r_src + AW'(8);
      r_dst <= r_dst + AW'(8);
      r_rem <= r_rem - CW'(1);
    end
  end

  assign o_src       = r_src;
  assign o_dst       = r_dst;
  assign o_remaining = r_rem;
  assign o_last      = (r_rem == CW'(1));

endmodule

// File: rtl/ahb_dma_master.sv
// Single-channel AHB-lite memory-to-memory DMA: alternating single read/write.
// Optional DMA_IRQ_EN adds a sticky completion interrupt (irq/irq_clr).
module ahb_dma_master
  import ahb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int CW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [CW-1:0] word_cnt,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] remaining,
`ifdef DMA_IRQ_EN
  output logic          irq,
  input  logic          irq_clr,
`endif
  output dma_state_t    o_dbg_state,
  ahb_dma_master_if.master bus
);

  dma_state_t    r_state;
  dma_state_t    w_next;
  logic          r_phase_wr;
  logic [DW-1:0] r_buf;
  logic [AW-1:0] w_src;
  logic [AW-1:0] w_dst;
  logic          w_last;
  logic          w_load;
  logic          w_rd_cap;
  logic          w_step;
  logic          w_breq;
  logic [1:0]    w_htrans;
  logic [AW-1:0] w_haddr;
  logic          w_hwrite;

  assign w_load   = (r_state == DMA_IDLE) && start;
  assign w_rd_cap = (r_state == DMA_RD_D) && bus.HREADY;
  assign w_step   = (r_state == DMA_WR_D) && bus.HREADY;

  dma_xfer_ctr #(.AW(AW), .CW(CW)) u_ctr (
    .i_clk       (HCLK),
    .i_rst       (HRESET),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_src       (src_addr),
    .i_dst       (dst_addr),
    .i_cnt       (word_cnt),
    .o_src       (w_src),
    .o_dst       (w_dst),
    .o_remaining (remaining),
    .o_last      (w_last)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= DMA_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_breq   = 1'b0;
    w_htrans = HTRANS_IDLE;
    w_haddr  = '0;
    w_hwrite = 1'b0;
    unique case (r_state)
      DMA_IDLE: begin
        if (start) w_next = (word_cnt != '0) ? DMA_REQ : DMA_DONE;
      end
      DMA_REQ: begin
        w_breq = 1'b1;
        // The phase flag resumes a pending write if the grant was lost after its read.
        if (bus.HGRANT && bus.HREADY) w_next = r_phase_wr ? DMA_WR_A : DMA_RD_A;
      end
      DMA_RD_A: begin
        w_breq   = 1'b1;
        w_htrans = HTRANS_NONSEQ;
        w_haddr  = w_src;
        if (bus.HREADY) w_next = DMA_RD_D;
      end
      DMA_RD_D: begin
        w_breq = 1'b1;
        if (bus.HREADY) w_next = bus.HGRANT ? DMA_WR_A : DMA_REQ;
      end
      DMA_WR_A: begin
        w_breq   = 1'b1;
        w_htrans = HTRANS_NONSEQ;
        w_haddr  = w_dst;
        w_hwrite = 1'b1;
        if (bus.HREADY) w_next = DMA_WR_D;
      end
      DMA_WR_D: begin
        w_breq = 1'b1;
        if (bus.HREADY) begin
          if (w_last || abort) w_next = DMA_DONE;
          else                 w_next = bus.HGRANT ? DMA_RD_A : DMA_REQ;
        end
      end
      DMA_DONE: w_next = DMA_IDLE;
      default:  w_next = DMA_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_phase_wr <= 1'b0;
      r_buf      <= '0;
    end else begin
      if (w_load)        r_phase_wr <= 1'b0;
      else if (w_rd_cap) r_phase_wr <= 1'b1;
      else if (w_step)   r_phase_wr <= 1'b0;
      if (w_rd_cap) r_buf <= bus.HRDATA;
    end
  end

`ifdef DMA_IRQ_EN
  logic r_irq;

  // Set has priority over a simultaneous clear.
  always_ff @(posedge HCLK) begin
    if (HRESET)                    r_irq <= 1'b0;
    else if (r_state == DMA_DONE)  r_irq <= 1'b1;
    else if (irq_clr)              r_irq <= 1'b0;
  end

  assign irq = r_irq;
`endif

  assign busy          = (r_state != DMA_IDLE);
  assign done          = (r_state == DMA_DONE);
  assign o_dbg_state   = r_state;
  assign bus.HBUSREQ   = w_breq;
  assign bus.HTRANS    = w_htrans;
  assign bus.HADDR     = w_haddr;
  assign bus.HWRITE    = w_hwrite;
  assign bus.HWDATA    = r_buf;
  assign bus.HSIZE     = HSIZE_DWORD;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_DATA;
  assign bus.HMASTLOCK = 1'b0;

endmodule
